// File: rtl/ex_stage_mc_pkg.sv
// ---------------------------------------------------------------------------
// ex_stage_mc_pkg
// Shared definitions for the mips_16 execute stage: default widths, ALU opcode
// encodings and the execute-stage state encoding. Imported by the execute
// stage, its interface and the sequential multiplier.
// ---------------------------------------------------------------------------
package ex_stage_mc_pkg;

    localparam int EX_DATA_W = 16;
    localparam int EX_WB_W   = 22;
    localparam int EX_DEST_W = 3;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_AND    = 4'd3,
        OP_OR     = 4'd4,
        OP_XOR    = 4'd5,
        OP_NOT    = 4'd6,
        OP_SLL    = 4'd7,
        OP_SRL    = 4'd8,
        OP_SRA    = 4'd9,
        OP_PASS_B = 4'd10,
        OP_MUL    = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ex_stage_mc_if.sv
// ---------------------------------------------------------------------------
// ex_stage_mc_if
// Bundles the execute stage's upstream handshake (in_*), downstream result
// handshake (out_*) and the hazard-detection outputs (ex_*).
//   slave  : the execute stage itself
//   master : the environment (issue logic upstream, write-back downstream)
// ---------------------------------------------------------------------------
interface ex_stage_mc_if
    import ex_stage_mc_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int WB_W   = EX_WB_W,
    parameter int DEST_W = EX_DEST_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [DEST_W-1:0] in_dest;
    logic [WB_W-1:0]   in_wb;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DEST_W-1:0] out_dest;
    logic [WB_W-1:0]   out_wb;

    logic [DEST_W-1:0] ex_op_dest;
    logic              ex_dest_valid;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_dest, in_wb, out_ready,
        output in_ready, out_valid, out_result, out_dest, out_wb,
        output ex_op_dest, ex_dest_valid
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_dest, in_wb, out_ready,
        input  in_ready, out_valid, out_result, out_dest, out_wb,
        input  ex_op_dest, ex_dest_valid
    );

endinterface

// File: rtl/ex_stage_mc_mul.sv
// ---------------------------------------------------------------------------
// ex_mul_seq
// Iterative shift-add multiplier, one partial product per clock. A start pulse
// loads the operands; DATA_W cycles later the low DATA_W bits of the unsigned
// product are in 'product' and stay there until the next start.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   start         load a/b and begin (ignored while busy is not checked: the
//                 caller only starts from its idle state)
//   a, b          operands
//   done          high during the cycle whose edge adds the last partial
//                 product; 'product' is final after that edge
//   product       accumulator (low DATA_W bits of a*b)
// ---------------------------------------------------------------------------
module ex_mul_seq
    import ex_stage_mc_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;

    // A non-zero count means a multiply is in flight.
    assign done    = (cnt == CNT_W'(1));
    assign product = acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CNT_W'(DATA_W);
        end else if (cnt != '0) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_stage_mc.sv
// ---------------------------------------------------------------------------
// ex_stage_mc
// Execute stage of the mips_16 pipeline. Single-cycle ALU ops land in the
// output register one edge after acceptance; MUL (when built in) runs on the
// iterative multiplier for DATA_W cycles and is then loaded into the same
// output register. Results are delivered in acceptance order.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   ex_stage_mc_if.slave: in_* (request handshake), out_* (result
//         handshake), ex_op_dest/ex_dest_valid (destination held in the stage)
// Build option:
//   EX_STAGE_MC_MUL_EN  defined   -> multi-cycle MUL via ex_mul_seq
//                       undefined -> no multiplier; MUL is a NOP (result 0)
// ---------------------------------------------------------------------------
module ex_stage_mc
    import ex_stage_mc_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int WB_W   = EX_WB_W,
    parameter int DEST_W = EX_DEST_W
) (
    input  logic          clk,
    input  logic          rst,
    ex_stage_mc_if.slave  bus
);

    localparam int SHAMT_W = $clog2(DATA_W);

    state_e            state;
    logic              vld_p1;
    logic [DATA_W-1:0] res_p1;
    logic [DEST_W-1:0] dest_p1;
    logic [WB_W-1:0]   wb_p1;
    logic [DEST_W-1:0] mul_dest;
    logic [WB_W-1:0]   mul_wb;

    logic              out_free;
    logic              in_ready;
    logic              accept;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    function automatic logic [DATA_W-1:0] alu(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [SHAMT_W-1:0]       sh;
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] sra_s;
        logic [DATA_W-1:0]        r;
        sh    = b[SHAMT_W-1:0];
        a_s   = a;
        sra_s = a_s >>> sh;
        r     = '0;
        case (op)
            OP_ADD:    r = a + b;
            OP_SUB:    r = a - b;
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NOT:    r = ~a;
            OP_SLL:    r = a << sh;
            OP_SRL:    r = a >> sh;
            OP_SRA:    r = sra_s;
            OP_PASS_B: r = b;
            // NOP, MUL (handled elsewhere or disabled) and undefined codes
            default:   r = '0;
        endcase
        return r;
    endfunction

    assign out_free = !vld_p1 || bus.out_ready;
    assign in_ready = rst && (state == IDLE) && out_free;
    assign accept   = bus.in_valid && in_ready;

`ifdef EX_STAGE_MC_MUL_EN
    localparam bit MUL_EN = 1'b1;

    logic mul_start;
    assign mul_start = accept && (bus.in_op == OP_MUL);

    ex_mul_seq #(
        .DATA_W  (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    localparam bit MUL_EN = 1'b0;

    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    // ---- stage p0 -> p1: operation / multiply result into output register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            vld_p1   <= 1'b0;
            res_p1   <= '0;
            dest_p1  <= '0;
            wb_p1    <= '0;
            mul_dest <= '0;
            mul_wb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (MUL_EN && (bus.in_op == OP_MUL)) begin
                            // Output is empty or drained this edge.
                            state    <= MUL_BUSY;
                            mul_dest <= bus.in_dest;
                            mul_wb   <= bus.in_wb;
                            vld_p1   <= 1'b0;
                        end else begin
                            vld_p1  <= 1'b1;
                            res_p1  <= alu(bus.in_op, bus.in_a, bus.in_b);
                            dest_p1 <= bus.in_dest;
                            wb_p1   <= bus.in_wb;
                        end
                    end else if (vld_p1 && bus.out_ready) begin
                        vld_p1 <= 1'b0;
                    end
                end
                MUL_BUSY: begin
                    if (vld_p1 && bus.out_ready) begin
                        vld_p1 <= 1'b0;
                    end
                    if (mul_done) begin
                        state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (out_free) begin
                        vld_p1  <= 1'b1;
                        res_p1  <= mul_product;
                        dest_p1 <= mul_dest;
                        wb_p1   <= mul_wb;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = vld_p1;
    assign bus.out_result = res_p1;
    assign bus.out_dest   = dest_p1;
    assign bus.out_wb     = wb_p1;

    // A multiply in flight owns the destination; otherwise the held result does.
    assign bus.ex_dest_valid = (state != IDLE) || vld_p1;
    assign bus.ex_op_dest    = (state != IDLE) ? mul_dest :
                               (vld_p1 ? dest_p1 : '0);

endmodule

// File: tb/tb_ex_stage_mc.sv
module tb_ex_stage_mc;
    import ex_stage_mc_pkg::*;

`ifdef EX_STAGE_MC_MUL_EN
    localparam bit TB_MUL_EN = 1'b1;
`else
    localparam bit TB_MUL_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    typedef struct {
        logic [15:0] r;
        logic [2:0]  d;
        logic [21:0] w;
    } exp_t;

    exp_t exp_q[$];

    ex_stage_mc_if #(.DATA_W(16), .WB_W(22), .DEST_W(3)) bif ();

    ex_stage_mc #(.DATA_W(16), .WB_W(22), .DEST_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural result of one operation, from the opcode definitions.
    function automatic logic [15:0] ref_alu(input int op, input longint unsigned a,
                                            input longint unsigned b);
        longint unsigned m;
        longint unsigned p2;
        longint          s;
        longint          q;
        longint unsigned r;
        m  = 65536;
        p2 = 1 << (b % 16);
        r  = 0;
        case (op)
            1:  r = (a + b) % m;
            2:  r = (a + m - b) % m;
            3:  r = a & b;
            4:  r = a | b;
            5:  r = a ^ b;
            6:  r = m - 1 - a;
            7:  r = (a * p2) % m;
            8:  r = a / p2;
            9: begin
                s = (a >= 32768) ? longint'(a) - 65536 : longint'(a);
                if (s < 0) q = -((-s + longint'(p2) - 1) / longint'(p2));
                else       q = s / longint'(p2);
                r = longint'(unsigned'(q + 65536)) % m;
            end
            10: r = b;
            11: r = TB_MUL_EN ? (a * b) % m : 0;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] d, input logic [21:0] w);
        bif.in_valid = v;
        bif.in_op    = op;
        bif.in_a     = a;
        bif.in_b     = b;
        bif.in_dest  = d;
        bif.in_wb    = w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0, 22'd0);
        bif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bif.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", bif.in_ready);
        else n_pass++;
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.out_result !== 16'd0 || bif.out_dest !== 3'd0 ||
            bif.out_wb !== 22'd0)
            $display("FAIL reset_out got v=%b r=%h d=%0d w=%h want all 0", bif.out_valid,
                     bif.out_result, bif.out_dest, bif.out_wb);
        else n_pass++;
        n_checks++;
        if (bif.ex_dest_valid !== 1'b0 || bif.ex_op_dest !== 3'd0)
            $display("FAIL reset_ex got %b/%0d want 0/0", bif.ex_dest_valid, bif.ex_op_dest);
        else n_pass++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_add();
        drive(1'b1, OP_ADD, 16'd12345, 16'd12345, 3'd4, 22'h0cad28);
        bif.out_ready = 1'b1;
        step();
        drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0, 22'd0);
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.out_result !== 16'd24690)
            $display("FAIL add_result got v=%b r=%0d want 1/24690", bif.out_valid, bif.out_result);
        else n_pass++;
        n_checks++;
        if (bif.out_dest !== 3'd4 || bif.out_wb !== 22'h0cad28)
            $display("FAIL add_fields got d=%0d w=%h want 4/0cad28", bif.out_dest, bif.out_wb);
        else n_pass++;
        n_checks++;
        if (bif.ex_dest_valid !== 1'b1 || bif.ex_op_dest !== 3'd4)
            $display("FAIL add_ex got %b/%0d want 1/4", bif.ex_dest_valid, bif.ex_op_dest);
        else n_pass++;
        step();
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.ex_dest_valid !== 1'b0)
            $display("FAIL add_drain got v=%b exv=%b want 0/0", bif.out_valid, bif.ex_dest_valid);
        else n_pass++;
    endtask

    task automatic test_wrap_sra();
        drive(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 3'd1, 22'h1);
        step();
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.out_result !== 16'h0000)
            $display("FAIL add_wrap got v=%b r=%h want 1/0000", bif.out_valid, bif.out_result);
        else n_pass++;
        drive(1'b1, OP_SRA, 16'h8000, 16'd3, 3'd2, 22'h2);
        step();
        drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0, 22'd0);
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.out_result !== 16'hF000 || bif.out_dest !== 3'd2)
            $display("FAIL sra got v=%b r=%h d=%0d want 1/f000/2", bif.out_valid,
                     bif.out_result, bif.out_dest);
        else n_pass++;
        step();
    endtask

    task automatic test_stall();
        drive(1'b1, OP_XOR, 16'h00FF, 16'h0F0F, 3'd3, 22'h3);
        step();
        bif.out_ready = 1'b0;
        drive(1'b1, OP_OR, 16'h0001, 16'h0002, 3'd5, 22'h5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (bif.in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", bif.in_ready);
            else n_pass++;
            step();
            n_checks++;
            if (bif.out_valid !== 1'b1 || bif.out_result !== 16'h0FF0 || bif.out_dest !== 3'd3)
                $display("FAIL stall_hold got v=%b r=%h d=%0d want 1/0ff0/3", bif.out_valid,
                         bif.out_result, bif.out_dest);
            else n_pass++;
        end
        bif.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bif.in_ready !== 1'b1) $display("FAIL stall_release_ready got %b want 1", bif.in_ready);
        else n_pass++;
        step();
        drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0, 22'd0);
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.out_result !== 16'h0003 || bif.out_dest !== 3'd5)
            $display("FAIL stall_next got v=%b r=%h d=%0d want 1/0003/5", bif.out_valid,
                     bif.out_result, bif.out_dest);
        else n_pass++;
        step();
    endtask

    task automatic test_all_ops();
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] want;
        bif.out_ready = 1'b1;
        for (int op = 0; op < 16; op++) begin
            if (TB_MUL_EN && op == 11) continue;
            a = 16'($urandom);
            b = 16'($urandom);
            want = ref_alu(op, a, b);
            drive(1'b1, 4'(op), a, b, 3'(op), 22'(op));
            step();
            n_checks++;
            if (bif.out_valid !== 1'b1 || bif.out_result !== want)
                $display("FAIL op%0d a=%h b=%h got v=%b r=%h want 1/%h", op, a, b,
                         bif.out_valid, bif.out_result, want);
            else n_pass++;
        end
        drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0, 22'd0);
        step();
    endtask

`ifdef EX_STAGE_MC_MUL_EN
    task automatic test_mul();
        drive(1'b1, OP_MUL, 16'd300, 16'd200, 3'd2, 22'h2a);
        bif.out_ready = 1'b1;
        step();
        drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0, 22'd0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            n_checks++;
            if (bif.in_ready !== 1'b0 || bif.ex_dest_valid !== 1'b1 || bif.ex_op_dest !== 3'd2 ||
                bif.out_valid !== 1'b0)
                $display("FAIL mul_busy cyc%0d got rdy=%b exv=%b exd=%0d ov=%b want 0/1/2/0", k,
                         bif.in_ready, bif.ex_dest_valid, bif.ex_op_dest, bif.out_valid);
            else n_pass++;
            step();
        end
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.out_result !== 16'hEA60 || bif.out_dest !== 3'd2 ||
            bif.out_wb !== 22'h2a)
            $display("FAIL mul_result got v=%b r=%h d=%0d w=%h want 1/ea60/2/2a", bif.out_valid,
                     bif.out_result, bif.out_dest, bif.out_wb);
        else n_pass++;
        step();
    endtask

    task automatic test_mul_reset();
        bit seen;
        drive(1'b1, OP_MUL, 16'd7, 16'd9, 3'd6, 22'h6);
        bif.out_ready = 1'b1;
        step();
        drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0, 22'd0);
        repeat (4) step();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.ex_dest_valid !== 1'b0 || bif.in_ready !== 1'b0)
            $display("FAIL mulrst_async got ov=%b exv=%b rdy=%b want 0/0/0", bif.out_valid,
                     bif.ex_dest_valid, bif.in_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bif.in_ready !== 1'b1) $display("FAIL mulrst_idle got rdy=%b want 1", bif.in_ready);
        else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bif.out_valid !== 1'b0 || bif.ex_dest_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL mulrst_ghost got a result after reset want none");
        else n_pass++;
        drive(1'b1, OP_ADD, 16'd1, 16'd1, 3'd1, 22'h1);
        step();
        drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0, 22'd0);
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.out_result !== 16'd2)
            $display("FAIL mulrst_add got v=%b r=%0d want 1/2", bif.out_valid, bif.out_result);
        else n_pass++;
        step();
    endtask
`else
    task automatic test_mul_disabled();
        drive(1'b1, OP_MUL, 16'd3, 16'd3, 3'd7, 22'h7);
        bif.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bif.in_ready !== 1'b1) $display("FAIL nomul_ready cyc%0d got %b want 1", k,
                                                bif.in_ready);
            else n_pass++;
            step();
            n_checks++;
            if (bif.out_valid !== 1'b1 || bif.out_result !== 16'd0 || bif.out_dest !== 3'd7)
                $display("FAIL nomul_result got v=%b r=%h d=%0d want 1/0000/7", bif.out_valid,
                         bif.out_result, bif.out_dest);
            else n_pass++;
        end
        drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0, 22'd0);
        step();
    endtask
`endif

    // Random traffic with back-pressure; results are checked in acceptance order
    // against the behavioural model, and held outputs must not change while stalled.
    task automatic test_random();
        bit          hold_pend;
        logic [15:0] h_r;
        logic [2:0]  h_d;
        logic [21:0] h_w;
        exp_t        e;
        int          budget;
        hold_pend = 1'b0;
        h_r = '0;
        h_d = '0;
        h_w = '0;
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            if (c < 500) begin
                drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom),
                      16'($urandom), 3'($urandom), 22'($urandom));
                bif.out_ready = 1'($urandom_range(0, 3) != 0);
            end else begin
                drive(1'b0, 4'd0, 16'd0, 16'd0, 3'd0, 22'd0);
                bif.out_ready = 1'b1;
            end
            @(negedge clk);
            if (hold_pend) begin
                n_checks++;
                if (bif.out_valid !== 1'b1 || bif.out_result !== h_r || bif.out_dest !== h_d ||
                    bif.out_wb !== h_w)
                    $display("FAIL rnd_hold got v=%b r=%h d=%0d w=%h want 1/%h/%0d/%h",
                             bif.out_valid, bif.out_result, bif.out_dest, bif.out_wb, h_r, h_d, h_w);
                else n_pass++;
            end
            if (bif.in_valid && bif.in_ready) begin
                e.r = ref_alu(int'(bif.in_op), bif.in_a, bif.in_b);
                e.d = bif.in_dest;
                e.w = bif.in_wb;
                exp_q.push_back(e);
            end
            if (bif.out_valid === 1'b1 && bif.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rnd_extra got r=%h want no output", bif.out_result);
                end else begin
                    e = exp_q.pop_front();
                    if (bif.out_result !== e.r || bif.out_dest !== e.d || bif.out_wb !== e.w)
                        $display("FAIL rnd_out got r=%h d=%0d w=%h want %h/%0d/%h",
                                 bif.out_result, bif.out_dest, bif.out_wb, e.r, e.d, e.w);
                    else n_pass++;
                end
            end
            hold_pend = (bif.out_valid === 1'b1) && !bif.out_ready;
            h_r = bif.out_result;
            h_d = bif.out_dest;
            h_w = bif.out_wb;
            @(posedge clk);
            #1;
        end
        budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            @(negedge clk);
            if (bif.out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bif.out_result !== e.r || bif.out_dest !== e.d || bif.out_wb !== e.w)
                    $display("FAIL rnd_drain got r=%h d=%0d w=%h want %h/%0d/%h",
                             bif.out_result, bif.out_dest, bif.out_wb, e.r, e.d, e.w);
                else n_pass++;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rnd_timeout got %0d pending want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bif.out_ready = 1'b1;
        test_reset();
        test_add();
        test_wrap_sra();
        test_stall();
        test_all_ops();
`ifdef EX_STAGE_MC_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning operand and result width.
REQ-002 The block SHALL have parameter WB_W, default 22, meaning width of the opaque write-back control field carried alongside each operation.
REQ-003 The block SHALL have parameter DEST_W, default 3, meaning register-file destination address width.
REQ-004 Port clk  input  1  rising-edge clock, the only clock.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 Port in_valid  input  1  operation presented.
REQ-007 Port in_ready  output  1  operation accepted when in_valid and in_ready are both high at a rising edge.
REQ-008 Port in_op  input  4  ALU opcode, encodings from the shared package.
REQ-009 Port in_a, in_b  input  DATA_W  operands.
REQ-010 Port in_dest  input  DEST_W  destination register.
REQ-011 Port in_wb  input  WB_W  pass-through control.
REQ-012 Port out_valid  output  1  result register holds a result.
REQ-013 Port out_ready  input  1  downstream consumes the result at a rising edge when out_valid and out_ready are both high.
REQ-014 Port out_result  output  DATA_W; out_dest  output  DEST_W; out_wb  output  WB_W  registered result fields.
REQ-015 Port ex_op_dest  output  DEST_W; ex_dest_valid  output  1  destination of the operation currently inside the stage (busy multiply or held output), for hazard detection.

Function
REQ-016 Opcodes SHALL be NOP, ADD, SUB, AND, OR, XOR, NOT(a), SLL, SRL, SRA (shift amount in_b[log2(DATA_W)-1:0]), PASS_B and MUL; any other code SHALL behave as NOP with result 0.
REQ-017 Arithmetic SHALL wrap modulo 2^DATA_W; MUL SHALL return the low DATA_W bits of the unsigned product.
REQ-018 Single-cycle ops SHALL have latency 1: accepted at edge N, out_valid high after edge N with result, dest and wb captured.
REQ-019 The state machine SHALL have states IDLE, MUL_BUSY and MUL_DONE.
REQ-020 In IDLE, accepting MUL SHALL go to MUL_BUSY for exactly DATA_W cycles, then to MUL_DONE.
REQ-021 In MUL_DONE, the product SHALL be loaded into the output register on the first edge where the output register is empty or being consumed, and the state SHALL return to IDLE.
REQ-022 in_ready SHALL equal (state==IDLE) and (!out_valid or out_ready), combinationally.
REQ-023 While out_valid is high and out_ready is low, all out_* SHALL hold stable.
REQ-024 Simultaneous consume and accept SHALL load the new result with no bubble.
REQ-025 ex_dest_valid SHALL be high with ex_op_dest = that op's dest while the state is MUL_BUSY or MUL_DONE; otherwise it SHALL be high with out_dest while out_valid is high; otherwise ex_dest_valid=0 and ex_op_dest=0.
REQ-026 NOP SHALL produce an output with out_valid high and result 0; upstream drops bubbles by holding in_valid low.

Reset
REQ-027 rst low SHALL asynchronously clear out_valid, out_result, out_dest, out_wb, ex_dest_valid and ex_op_dest to 0, set the state to IDLE, and clear the multiplier counter and accumulator.
REQ-028 Reset during MUL_BUSY SHALL abandon the multiply; no result SHALL appear after release.
REQ-029 in_ready SHALL be low while rst is low.

Configuration
REQ-030 Macro EX_STAGE_MC_MUL_EN defined: MUL SHALL behave as in REQ-020/021.
REQ-031 Macro EX_STAGE_MC_MUL_EN undefined: the multiplier SHALL not be instantiated, and MUL SHALL behave as a single-cycle NOP with result 0, so MUL_BUSY is never entered.

Structure
REQ-032 Opcode encodings, state encodings and the default widths SHALL reside in the shared mips_16 package/defines file.
REQ-033 The iterative shift-add multiplier SHALL be sub-module ex_mul_seq with start/done handshake, one partial product per cycle.

Verification
REQ-034 ADD a=12345 b=12345 dest=4 wb=22'h0cad28, out_ready=1 -> one edge later out_valid=1, out_result=24690, out_dest=4, out_wb=22'h0cad28, ex_dest_valid=1, ex_op_dest=4.
REQ-035 ADD 16'hFFFF+16'h0001, then SRA 16'h8000 by 3 -> results 16'h0000 then 16'hF000 on consecutive cycles.
REQ-036 out_ready=0 for 5 cycles after XOR 16'h00FF^16'h0F0F -> out_result stays 16'h0FF0, in_ready=0, and a second op is accepted on the edge out_ready returns to 1.
REQ-037 MUL 300*200 dest=2 -> in_ready low for 17 cycles, ex_op_dest=2 throughout, out_result=16'hEA60 exactly DATA_W+1 edges after acceptance.
REQ-038 rst asserted 5 cycles into a MUL -> immediate out_valid=0 and state IDLE; no output after release; the next ADD 1+1 returns 2.
REQ-039 Build without EX_STAGE_MC_MUL_EN, MUL 3*3 -> result 0 after 1 cycle, in_ready never drops.
